// File: rtl/gemm_pkg.sv
// Shared types and constants for the GEMM result path.
// Holds the packer state encoding and error bit positions.
package gemm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ce_pack_state_t;

  localparam int CE_PACK_ERR_OVF   = 0;
  localparam int CE_PACK_ERR_UNEXP = 1;
  localparam int CE_PACK_ERR_START = 2;

  // Saturating increment: status counters stick at 0xFFFF instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ce_result_packer_if.sv
// Packed-result output bus from the packer to the tile result FIFO.
// The packer is the master; the downstream FIFO drives i_result_full.
interface ce_result_packer_if #(
    parameter int ELEM_W = 16,
    parameter int PACK_N = 4
);
    logic [PACK_N*ELEM_W-1:0] o_result_data;
    logic [PACK_N-1:0]        o_result_keep;
    logic                     o_result_last;
    logic                     o_result_valid;
    logic                     i_result_full;

    modport master (
        output o_result_data, o_result_keep, o_result_last, o_result_valid,
        input  i_result_full
    );

    modport slave (
        input  o_result_data, o_result_keep, o_result_last, o_result_valid,
        output i_result_full
    );
endinterface

// File: rtl/ce_pack_fifo.sv
// Show-ahead FIFO with a registered occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module ce_pack_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    output logic [W-1:0]  o_rdata,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign o_full  = (count_q == FULL_CNT);
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign push_ok = i_push && (!o_full || i_pop);
    assign pop_ok  = i_pop && !o_empty;
    // Gate the head so stale storage never shows on the bus.
    assign o_rdata = o_empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    // NOTE: the storage array has no reset; only pointers and count need one.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr_q] <= i_wdata;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/ce_result_packer.sv
// Packs PACK_N converter results per word into a FIFO towards the tile result
// FIFO, with early stall, last-word tagging, counters and sticky error flags.
module ce_result_packer
    import gemm_pkg::*;
#(
    parameter int ELEM_W       = 16,
    parameter int PACK_N       = 4,
    parameter int DEPTH        = 16,
    parameter int STALL_MARGIN = 4
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic [15:0]        i_expected_count,
    input  logic [ELEM_W-1:0]  i_data,
    input  logic               i_valid,
    output logic               o_stall,
    ce_result_packer_if.master res,
    output logic               o_done,
    output logic [2:0]         o_error,
    output logic [15:0]        o_result_count,
    output logic [15:0]        o_word_count,
    output logic [1:0]         o_state
);
    localparam int WORD_W = PACK_N * ELEM_W;
    localparam int FIFO_W = WORD_W + PACK_N + 1;
    localparam int LANE_W = (PACK_N > 1) ? $clog2(PACK_N) : 1;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    ce_pack_state_t    state_q, state_d;
    logic [15:0]       expected_q, expected_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic [15:0]       result_count_q, result_count_d;
    logic [15:0]       word_count_q, word_count_d;
    logic [2:0]        error_q, error_d;
    logic              done_q, done_d, stall_q, stall_d;

    logic              fifo_push, fifo_full, fifo_empty, pop;
    logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;
    logic [WORD_W-1:0] merged;
    logic [PACK_N-1:0] keep_new;
    logic              is_last, complete, blocked, going_empty;

    ce_pack_fifo #(.W(FIFO_W), .DEPTH(DEPTH)) u_fifo (
        .i_clk, .i_reset_n,
        .i_push (fifo_push), .i_wdata(fifo_wdata), .i_pop(pop),
        .o_rdata(fifo_rdata), .o_count(fifo_count),
        .o_full (fifo_full), .o_empty(fifo_empty)
    );

    assign pop = !fifo_empty && !res.i_result_full;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no latch is inferred.
        state_d        = state_q;
        expected_d     = expected_q;
        lane_d         = lane_q;
        pack_d         = pack_q;
        result_count_d = result_count_q;
        word_count_d   = pop ? sat_inc(word_count_q) : word_count_q;
        error_d        = error_q;
        done_d         = 1'b0;
        fifo_push      = 1'b0;

        merged = pack_q;
        merged[int'(lane_q)*ELEM_W +: ELEM_W] = i_data;
        for (int i = 0; i < PACK_N; i++) keep_new[i] = (i <= int'(lane_q));
        is_last     = ({1'b0, result_count_q} + 17'd1) == {1'b0, expected_q};
        complete    = (lane_q == LANE_W'(PACK_N - 1)) || is_last;
        blocked     = fifo_full && !pop;
        going_empty = fifo_empty || (fifo_count == CNT_W'(1) && pop);
        fifo_wdata  = {is_last, keep_new, merged};

        unique case (state_q)
            IDLE: if (i_start) begin
                expected_d     = i_expected_count;
                lane_d         = '0;
                pack_d         = '0;
                result_count_d = '0;
                word_count_d   = '0;
                error_d        = '0;
                state_d        = (i_expected_count == '0) ? DONE : RUN;
            end
            RUN: if (i_valid) begin
                if (complete && blocked) begin
                    // Element is lost; pack register keeps its lanes for the retry.
                    error_d[CE_PACK_ERR_OVF] = 1'b1;
                end else begin
                    result_count_d = sat_inc(result_count_q);
                    if (complete) begin
                        fifo_push = 1'b1;
                        pack_d    = '0;
                        lane_d    = '0;
                        if (is_last) state_d = DRAIN;
                    end else begin
                        pack_d = merged;
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end
            DRAIN: if (going_empty) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (i_valid && state_q != RUN)  error_d[CE_PACK_ERR_UNEXP] = 1'b1;
        if (i_start && state_q != IDLE) error_d[CE_PACK_ERR_START] = 1'b1;

        done_d  = (state_d == DONE);
        stall_d = (int'(fifo_count) + int'(fifo_push) - int'(pop)) >= (DEPTH - STALL_MARGIN);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q        <= IDLE;
            expected_q     <= '0;
            lane_q         <= '0;
            pack_q         <= '0;
            result_count_q <= '0;
            word_count_q   <= '0;
            error_q        <= '0;
            done_q         <= 1'b0;
            stall_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            expected_q     <= expected_d;
            lane_q         <= lane_d;
            pack_q         <= pack_d;
            result_count_q <= result_count_d;
            word_count_q   <= word_count_d;
            error_q        <= error_d;
            done_q         <= done_d;
            stall_q        <= stall_d;
        end
    end

    assign res.o_result_data  = fifo_rdata[WORD_W-1:0];
    assign res.o_result_keep  = fifo_rdata[WORD_W +: PACK_N];
    assign res.o_result_last  = fifo_rdata[FIFO_W-1];
    assign res.o_result_valid = !fifo_empty;
    assign o_stall            = stall_q;
    assign o_done             = done_q;
    assign o_error            = error_q;
    assign o_result_count     = result_count_q;
    assign o_word_count       = word_count_q;
    assign o_state            = state_q;
endmodule

// File: tb/tb_ce_result_packer.sv
// Randomized scoreboard bench for ce_result_packer: a queue-based reference
// model predicts words, counters, errors, stall and done timing.
module tb_ce_result_packer;
    localparam int ELEM_W = 16, PACK_N = 4, DEPTH = 16, STALL_MARGIN = 4;
    localparam int STALL_TH = DEPTH - STALL_MARGIN;

    logic        i_clk = 1'b0, i_reset_n = 1'b0, i_start = 1'b0, i_valid = 1'b0;
    logic [15:0] i_expected_count = '0, i_data = '0;
    logic        o_stall, o_done;
    logic [2:0]  o_error;
    logic [15:0] o_result_count, o_word_count;
    logic [1:0]  o_state;

    ce_result_packer_if #(.ELEM_W(ELEM_W), .PACK_N(PACK_N)) rif ();

    ce_result_packer #(.ELEM_W(ELEM_W), .PACK_N(PACK_N), .DEPTH(DEPTH),
                       .STALL_MARGIN(STALL_MARGIN)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start),
        .i_expected_count(i_expected_count), .i_data(i_data), .i_valid(i_valid),
        .o_stall(o_stall), .res(rif), .o_done(o_done), .o_error(o_error),
        .o_result_count(o_result_count), .o_word_count(o_word_count), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;
    word_t sb[$];

    int errors = 0, checks = 0;
    int done_seen = 0, done_cyc = -1;

    // Reference model state
    int          m_occ = 0, m_count = 0, m_exp = 0, m_words = 0, m_done_cyc = -1;
    bit          m_running = 0, m_tile_open = 0;
    logic [2:0]  m_err = '0;
    logic [15:0] m_lanes[$];
    int          elem_idx = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every downstream transfer.
    always @(negedge i_clk) begin
        if (i_reset_n && rif.o_result_valid && !rif.i_result_full) begin
            if (sb.size() == 0) check("unexpected_word", 64'(rif.o_result_valid), 64'd0);
            else begin
                word_t w;
                w = sb.pop_front();
                check("word_data", rif.o_result_data, w.data);
                check("word_keep", 64'(rif.o_result_keep), 64'(w.keep));
                check("word_last", 64'(rif.o_result_last), 64'(w.last));
            end
        end
        if (o_done) begin
            done_seen++;
            done_cyc = cyc;
        end
    end

    // One clock cycle: drive inputs, advance the model, then check stall next cycle.
    task automatic step(input bit v, input logic [15:0] d, input bit full,
                        input bit st, input logic [15:0] st_exp);
        bit pop_now, full_now, just_started, complete;
        i_valid = v; i_data = d; rif.i_result_full = full;
        i_start = st; i_expected_count = st_exp;

        full_now     = (m_occ == DEPTH);
        pop_now      = (m_occ > 0) && !full;
        just_started = 0;
        if (pop_now) begin
            m_occ--;
            m_words++;
            if (m_occ == 0 && !m_running && m_tile_open) begin
                m_done_cyc  = cyc + 1;
                m_tile_open = 0;
            end
        end
        if (st) begin
            if (m_running) m_err[2] = 1'b1;
            else begin
                just_started = 1;
                m_exp = int'(st_exp); m_count = 0; m_words = 0; m_err = '0;
                m_lanes.delete();
                m_running   = (st_exp != 0);
                m_tile_open = (st_exp != 0);
                if (st_exp == 0) m_done_cyc = cyc + 1;
            end
        end
        if (v) begin
            if (!m_running || just_started) m_err[1] = 1'b1;
            else begin
                complete = (m_lanes.size() == PACK_N - 1) || (m_count + 1 == m_exp);
                if (complete && full_now && !pop_now) m_err[0] = 1'b1;
                else begin
                    m_lanes.push_back(d);
                    m_count++;
                    if (complete) begin
                        word_t w;
                        w.data = '0;
                        for (int i = 0; i < m_lanes.size(); i++)
                            w.data = w.data | (64'(m_lanes[i]) << (16 * i));
                        w.keep = 4'((1 << m_lanes.size()) - 1);
                        w.last = (m_count == m_exp);
                        sb.push_back(w);
                        m_occ++;
                        m_lanes.delete();
                        if (w.last) m_running = 0;
                    end
                end
            end
        end
        @(posedge i_clk); #1;
        if (i_reset_n) check("stall", 64'(o_stall), 64'(m_occ >= STALL_TH));
    endtask

    task automatic run_tile(input int exp_n, input int vpct, input int fpct,
                            input int mid_start_at, input bit start_valid,
                            input int hold, input bit seq);
        int n;
        bit v, f, st;
        logic [15:0] d;
        done_seen = 0; done_cyc = -1; elem_idx = 0;
        step(start_valid, 16'($urandom), 1'b0, 1'b1, 16'(exp_n));
        check("state_after_start", 64'(o_state), (exp_n == 0) ? 64'd3 : 64'd1);
        n = 0;
        while ((m_running || m_occ > 0) && n < 4000) begin
            if (n < hold) begin
                v = m_running; f = 1'b1;
            end else begin
                v = m_running && ($urandom_range(99) < vpct);
                f = ($urandom_range(99) < fpct);
            end
            st = (n == mid_start_at) && m_running;
            d  = seq ? 16'h3C00 + 16'(elem_idx) : 16'($urandom);
            if (v) elem_idx++;
            step(v, d, f, st, 16'd5);
            n++;
        end
        if (n >= 4000) check("tile_timeout", 64'(n), 64'd0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b0, '0);
        check("done_pulses", 64'(done_seen), 64'd1);
        check("done_cycle", 64'(done_cyc), 64'(m_done_cyc));
        check("result_count", 64'(o_result_count), 64'(m_count));
        check("word_count", 64'(o_word_count), 64'(m_words));
        check("error", 64'(o_error), 64'(m_err));
        check("state_idle", 64'(o_state), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(rif.o_result_valid), 64'd0);
        check({tag, "_data"}, rif.o_result_data, 64'd0);
        check({tag, "_keep_last"}, 64'({rif.o_result_keep, rif.o_result_last}), 64'd0);
        check({tag, "_stall_done"}, 64'({o_stall, o_done}), 64'd0);
        check({tag, "_error"}, 64'(o_error), 64'd0);
        check({tag, "_counts"}, 64'({o_result_count, o_word_count}), 64'd0);
        check({tag, "_state"}, 64'(o_state), 64'd0);
    endtask

    initial begin
        rif.i_result_full = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_outputs("reset");
        i_reset_n = 1'b1;
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b0, 1'b0, '0);

        // Full words, then partial last word
        run_tile(8, 100, 0, -1, 1'b0, 0, 1'b1);
        check("fw_result_count", 64'(o_result_count), 64'd8);
        check("fw_word_count", 64'(o_word_count), 64'd2);
        run_tile(6, 100, 0, -1, 1'b0, 0, 1'b1);

        // Backpressure overflow: full held while elements keep arriving
        run_tile(80, 100, 30, -1, 1'b0, 75, 1'b0);
        check("ovf_flag", 64'(o_error), 64'd1);

        // Empty tile
        run_tile(0, 100, 0, -1, 1'b0, 0, 1'b0);

        // Protocol errors
        step(1'b1, 16'h1234, 1'b0, 1'b0, '0);
        check("idle_valid_err", 64'(o_error), 64'h2);
        run_tile(12, 70, 20, 3, 1'b0, 0, 1'b0);
        check("start_busy_err", 64'(o_error), 64'h4);
        run_tile(8, 100, 0, -1, 1'b1, 0, 1'b1);
        check("start_valid_err", 64'(o_error), 64'h2);

        // Reset mid-RUN after 5 elements
        done_seen = 0;
        step(1'b0, '0, 1'b0, 1'b1, 16'd20);
        for (int i = 0; i < 5; i++) step(1'b1, 16'h3C00 + 16'(i), 1'b1, 1'b0, '0);
        i_reset_n = 1'b0; i_valid = 1'b0; i_start = 1'b0; rif.i_result_full = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb.delete(); m_lanes.delete();
        m_occ = 0; m_running = 0; m_tile_open = 0; m_err = '0; m_count = 0; m_words = 0;
        repeat (3) @(posedge i_clk);
        #1;
        check("midreset_no_done", 64'(done_seen), 64'd0);
        i_reset_n = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0, '0);
        run_tile(8, 100, 0, -1, 1'b0, 0, 1'b1);
        check("after_reset_words", 64'(o_word_count), 64'd2);

        // Randomized tiles
        for (int t = 0; t < 8; t++)
            run_tile($urandom_range(1, 45), $urandom_range(30, 100),
                     $urandom_range(0, 70), -1, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ce_result_packer.md
# ce_result_packer

Parametrised result output stage for the GEMM compute engine. It sits between the GFP8→FP16 converter and the tile result FIFO. It packs PACK_N FP16 results per output word and buffers them in a DEPTH-word FIFO, so results are never silently dropped under backpressure. It gives the upstream BCV loop an early stall, tags the final word of a tile, and counts and flags every protocol violation.

## Interface
Parameters:
- ELEM_W, 16, width of one result element (FP16).
- PACK_N, 4, elements per output word; legal values 1, 2, 4, 8.
- DEPTH, 16, packed-word FIFO depth; power of two, ≥ 2.
- STALL_MARGIN, 4, free-word threshold for o_stall; 1 ≤ STALL_MARGIN < DEPTH.

Ports:
- i_clk  in  1  single clock; all logic on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle pulse; begins a tile and clears counters and errors.
- i_expected_count  in  16  number of results in this tile; sampled on accepted i_start.
- i_data  in  ELEM_W  result element from the converter.
- i_valid  in  1  i_data valid this cycle; there is no ready, and the source may ignore o_stall.
- o_stall  out  1  high when FIFO occupancy ≥ DEPTH−STALL_MARGIN.
- o_result_data  out  PACK_N*ELEM_W  packed word; lane 0 in bits [ELEM_W−1:0].
- o_result_keep  out  PACK_N  lane-valid mask, LSB = lane 0.
- o_result_last  out  1  word holds the tile's final element.
- o_result_valid  out  1  FIFO head valid.
- i_result_full  in  1  downstream cannot accept this cycle.
- o_done  out  1  one-cycle pulse when the tile is fully drained.
- o_error  out  3  sticky flags: [0] overflow drop, [1] unexpected result, [2] start while busy.
- o_result_count  out  16  elements accepted since the last start.
- o_word_count  out  16  words transferred downstream since the last start.
- o_state  out  2  debug state encoding.

## Operation
- **States:** IDLE=0, RUN=1, DRAIN=2, DONE=3.
- **IDLE:**
  - i_start with i_expected_count≠0 → RUN. This latches the expected count and clears lane index, pack register, counters and o_error.
  - i_start with i_expected_count=0 → DONE; no words are produced.
- **RUN, accepting i_valid:**
  - The element is written to lane lane_idx.
  - The word completes when lane_idx=PACK_N−1 or o_result_count+1 = expected.
  - A completing word is pushed at the same edge: {pack register lanes merged with the incoming lane, keep mask, last}. The pack register and lane_idx are then cleared.
  - keep has a 1 for each written lane. Unwritten lanes hold zero.
  - last=1 only for the word holding the expected-th element.
  - After the last push → DRAIN.
- **Push when FIFO full:**
  - A push is blocked only if the FIFO is full and no pop happens in the same cycle. Push and pop together at full is allowed.
  - On a blocked push, the incoming element is dropped and not counted. The pack register keeps its lanes, and o_error[0] is set.
- **Output side:**
  - A transfer occurs on o_result_valid && !i_result_full; it pops the head and increments o_word_count.
  - Head data stays stable while i_result_full=1.
- **DRAIN:** when the FIFO is empty → DONE.
- **DONE:** o_done=1 for exactly this cycle, then → IDLE.
- **i_valid outside RUN:** the element is ignored and o_error[1] is set.
- **i_start outside IDLE:** ignored, o_error[2] set, and the tile continues.
- **Counter width:** 16-bit counters saturate at 0xFFFF and never wrap.

## Timing
- **Reset values:** all outputs are 0 while i_reset_n=0, and the state is IDLE. The FIFO is emptied and the pack register cleared. Reset mid-tile aborts the tile with no o_done.
- **Latency:** the completing element at edge k makes o_result_valid=1 in the cycle after edge k. The FIFO is show-ahead with a registered count.
- **o_stall:** registered from occupancy, so it updates the cycle after a push or pop.
- **o_done:** the earliest o_done is one cycle after the pop that empties the FIFO in DRAIN. With expected=0, o_done comes one cycle after i_start.
- **Same-cycle events:**
  - i_start is checked before i_valid: in IDLE, an i_valid coincident with i_start sets error[1] and is not packed.
  - o_error updates the cycle after the violating input.

## Structure
- gemm_pkg gains:
  - typedef ce_pack_state_t (IDLE, RUN, DRAIN, DONE; 2 bits).
  - Constants CE_PACK_ERR_OVF=0, CE_PACK_ERR_UNEXP=1, CE_PACK_ERR_START=2.
- Sub-module ce_pack_fifo:
  - Synchronous show-ahead FIFO, width PACK_N*ELEM_W+PACK_N+1 and depth DEPTH.
  - Exposes count, full, empty and simultaneous push/pop at full.
- The packer FSM, lane register and counters stay in ce_result_packer.

## Test plan
All scenarios use the defaults PACK_N=4, DEPTH=16, STALL_MARGIN=4.
- **Full words:** expected=8, 8 back-to-back elements 0x3C00..0x3C07, i_result_full=0 → 2 words, keep=4'hF, last on word 2, o_done 1 cycle after the second pop, o_result_count=8, o_word_count=2.
- **Partial last word:** expected=6 → word 2 has keep=4'b0011, lanes 2–3 equal to 0, last=1.
- **Backpressure overflow:** i_result_full=1, expected=80, continuous i_valid ignoring stall.
  - o_stall rises after the 12th word push.
  - The 68th element is dropped with error[0]=1; the 69th completes word 17 once a pop occurs.
  - Release i_result_full → all buffered words are delivered intact.
- **Empty tile:** expected=0 → o_done one cycle after i_start, o_result_valid stays 0.
- **Protocol errors:** i_valid in IDLE → error=3'b010; i_start during RUN → error[2]=1, tile still completes. The next accepted i_start clears error.
- **Reset mid-RUN:** assert i_reset_n=0 after 5 elements → all outputs 0, state IDLE, no o_done. A new tile after reset behaves as in the full-words scenario.
